rsp_packetizer: RTL and testbench

- Response serializer in the REF_CLK domain, between the ALU/Register File result outputs and the write side of the asynchronous TX FIFO.
- Captures 16-bit ALU results and 8-bit register read data into a small response queue.
- Emits them as byte writes to the FIFO under FULL backpressure.
- Frees the system controller from per-byte FIFO sequencing.

---
 rtl/rsp_pkg.sv | 27 ++
 rtl/rsp_queue.sv | 52 +++++
 rtl/rsp_packetizer.sv | 135 +++++++++++++
 tb/tb_rsp_packetizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_pkg.sv
// Shared types for the response packetizer: entry kind, FSM states, queue entry layout.
package rsp_pkg;

  localparam int RSP_DATA_W = 8;

  typedef enum logic {
    RSP_RD  = 1'b0,
    RSP_ALU = 1'b1
  } rsp_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_LO  = 2'd1,
    ST_SEND_HI  = 2'd2
`ifdef RSP_PACKETIZER_CHECKSUM_EN
    ,
    ST_SEND_CHK = 2'd3
`endif
  } rsp_state_e;

  // Queue entries are stored flat as {kind, payload}; this is that layout at the default width.
  typedef struct packed {
    rsp_kind_e                 kind;
    logic [2*RSP_DATA_W-1:0]   payload;
  } rsp_entry_t;

endpackage

// File: rtl/rsp_queue.sv
// Synchronous response queue, 2 pushes / 1 pop per cycle; pushed entries visible next cycle.
// Callers gate pushes with full/free_cnt; free space is judged before any same-cycle pop.
module rsp_queue #(
  parameter int W     = 17,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0_vld,
  input  logic [W-1:0]  push0_dat,
  input  logic          push1_vld,
  input  logic [W-1:0]  push1_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   free_cnt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   used;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;

  assign used     = wr_ptr - rd_ptr;
  assign empty    = (used == '0);
  // DEPTH is a power of two, so the top bit of the occupancy is set only when full.
  assign full     = used[AW];
  assign free_cnt = (AW+1)'(DEPTH) - used;
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign wr_idx0  = wr_ptr[AW-1:0];
  assign wr_idx1  = wr_idx0 + 1'b1;

  always_ff @(posedge clk) begin
    if (push0_vld) mem[wr_idx0] <= push0_dat;
    if (push1_vld) mem[wr_idx1] <= push1_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push0_vld) + (AW+1)'(push1_vld);
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rsp_packetizer.sv
// Serializes ALU results (2 bytes) and register reads (1 byte) into TX FIFO writes; first write 2 cycles after the valid pulse.
// Stalls holding data while i_FIFO_FULL; RSP_PACKETIZER_CHECKSUM_EN appends an XOR checksum byte per response.
module rsp_packetizer
  import rsp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
  input  logic                    i_OUT_Valid,
  input  logic [DATA_WIDTH-1:0]   i_RdData,
  input  logic                    i_RdData_Valid,
  input  logic                    i_FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   o_FIFO_DATA,
  output logic                    o_WR_INC,
  output logic                    o_busy,
  output logic                    o_overflow
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int EW = PW + 1;
  localparam int AW = $clog2(QUEUE_DEPTH);

`ifdef RSP_PACKETIZER_CHECKSUM_EN
  localparam rsp_state_e AFTER_LAST = ST_SEND_CHK;
`else
  localparam rsp_state_e AFTER_LAST = ST_IDLE;
`endif

  logic [EW-1:0] alu_entry;
  logic [EW-1:0] rd_entry;
  logic [EW-1:0] push0_dat;
  logic          push0_vld;
  logic          push1_vld;
  logic          any_vld;
  logic          both_vld;
  logic          drop;
  logic [EW-1:0] head_dat;
  logic          q_empty;
  logic          q_full;
  logic [AW:0]   q_free;
  logic          pop;

  rsp_state_e    state_q;
  rsp_state_e    state_d;
  logic [EW-1:0] hold_q;
  logic          hold_is_alu;
  logic [DATA_WIDTH-1:0] hold_lo;
  logic [DATA_WIDTH-1:0] hold_hi;
  logic          overflow_q;

  assign alu_entry = {RSP_ALU, i_ALU_OUT};
  assign rd_entry  = {RSP_RD, {DATA_WIDTH{1'b0}}, i_RdData};
  assign any_vld   = i_OUT_Valid | i_RdData_Valid;
  assign both_vld  = i_OUT_Valid & i_RdData_Valid;

  // The ALU entry always takes the first slot, so on a simultaneous pair it is the RD entry that gets dropped.
  assign push0_dat = i_OUT_Valid ? alu_entry : rd_entry;
  assign push0_vld = any_vld && !q_full;
  assign push1_vld = both_vld && (q_free >= (AW+1)'(2));
  assign drop      = (any_vld && q_full) || (both_vld && !push1_vld);

  rsp_queue #(
    .W     (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (i_CLK),
    .rst       (i_RST),
    .push0_vld (push0_vld),
    .push0_dat (push0_dat),
    .push1_vld (push1_vld),
    .push1_dat (rd_entry),
    .pop       (pop),
    .head_dat  (head_dat),
    .empty     (q_empty),
    .full      (q_full),
    .free_cnt  (q_free)
  );

  assign hold_is_alu = (rsp_kind_e'(hold_q[PW]) == RSP_ALU);
  assign hold_lo     = hold_q[DATA_WIDTH-1:0];
  assign hold_hi     = hold_q[PW-1:DATA_WIDTH];

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= drop;
      if (pop) hold_q <= head_dat;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    o_WR_INC    = 1'b0;
    o_FIFO_DATA = '0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        o_FIFO_DATA = hold_lo;
        o_WR_INC    = !i_FIFO_FULL;
        if (!i_FIFO_FULL) state_d = hold_is_alu ? ST_SEND_HI : AFTER_LAST;
      end
      ST_SEND_HI: begin
        o_FIFO_DATA = hold_hi;
        o_WR_INC    = !i_FIFO_FULL;
        if (!i_FIFO_FULL) state_d = AFTER_LAST;
      end
`ifdef RSP_PACKETIZER_CHECKSUM_EN
      // RD payloads are zero-extended, so lo^hi is the checksum for both kinds.
      ST_SEND_CHK: begin
        o_FIFO_DATA = hold_lo ^ hold_hi;
        o_WR_INC    = !i_FIFO_FULL;
        if (!i_FIFO_FULL) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy     = !q_empty || (state_q != ST_IDLE);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_rsp_packetizer.sv
// Directed bench for rsp_packetizer: expected FIFO writes go to a scoreboard queue, a negedge monitor checks them.
module tb_rsp_packetizer;

`ifdef RSP_PACKETIZER_CHECKSUM_EN
  localparam int CX = 1;
`else
  localparam int CX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_out;
  logic        alu_vld;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic        fifo_full;
  logic [7:0]  fifo_data;
  logic        wr_inc;
  logic        busy;
  logic        overflow;

  rsp_packetizer #(.DATA_WIDTH(8), .QUEUE_DEPTH(2)) dut (
    .i_CLK          (clk),
    .i_RST          (rst),
    .i_ALU_OUT      (alu_out),
    .i_OUT_Valid    (alu_vld),
    .i_RdData       (rd_data),
    .i_RdData_Valid (rd_vld),
    .i_FIFO_FULL    (fifo_full),
    .o_FIFO_DATA    (fifo_data),
    .o_WR_INC       (wr_inc),
    .o_busy         (busy),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Start of cycle c: just after the edge that made cyc == c.
  task automatic at_start(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic pulse(input int c, input logic a_v, input logic [15:0] a, input logic r_v, input logic [7:0] r);
    at_start(c);
    alu_vld = a_v;
    alu_out = a;
    rd_vld  = r_v;
    rd_data = r;
    at_start(c + 1);
    alu_vld = 1'b0;
    rd_vld  = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("wr_while_full", {31'b0, wr_inc & fifo_full}, 32'd0);
    if (wr_inc) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: actual data=%0h required no write (cyc %0d)", fifo_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_data", {24'b0, fifo_data}, {24'b0, mon_e.d});
        if (mon_e.c >= 0) chk("wr_cycle", cyc, mon_e.c);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst       = 1'b1;
    alu_out   = '0;
    alu_vld   = 1'b0;
    rd_data   = '0;
    rd_vld    = 1'b0;
    fifo_full = 1'b0;

    at_start(3);
    rst = 1'b0;
    at_neg(3);
    chk("rst_wr_inc",   {31'b0, wr_inc},   32'd0);
    chk("rst_data",     {24'b0, fifo_data}, 32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);

    // ALU response: low byte then high byte
    k = cyc + 2;
    expect_byte(8'h5A, k + 2);
    expect_byte(8'hA5, k + 3);
    if (CX != 0) expect_byte(8'hFF, k + 4);
    pulse(k, 1'b1, 16'hA55A, 1'b0, 8'h00);
    at_neg(k + 1);
    chk("alu_busy_hi", {31'b0, busy}, 32'd1);
    at_neg(k + 4 + CX);
    chk("alu_busy_lo", {31'b0, busy}, 32'd0);

    // Register read response: single byte
    k = cyc + 2;
    expect_byte(8'h3C, k + 2);
    if (CX != 0) expect_byte(8'h3C, k + 3);
    pulse(k, 1'b0, 16'h0000, 1'b1, 8'h3C);
    at_neg(k + 3 + CX);
    chk("rd_busy_lo", {31'b0, busy}, 32'd0);

    // Simultaneous ALU and RD: ALU first, one idle cycle between responses
    k = cyc + 2;
    expect_byte(8'h34, k + 2);
    expect_byte(8'h12, k + 3);
    if (CX != 0) expect_byte(8'h26, k + 4);
    expect_byte(8'h77, k + 5 + CX);
    if (CX != 0) expect_byte(8'h77, k + 7);
    pulse(k, 1'b1, 16'h1234, 1'b1, 8'h77);
    at_neg(k + 1);
    chk("both_no_overflow", {31'b0, overflow}, 32'd0);
    at_neg(k + 6 + 2 * CX);
    chk("both_busy_lo", {31'b0, busy}, 32'd0);

    // Stall during the high byte of 16'hBEEF
    k = cyc + 2;
    expect_byte(8'hEF, k + 2);
    expect_byte(8'hBE, k + 8);
    if (CX != 0) expect_byte(8'h51, k + 9);
    pulse(k, 1'b1, 16'hBEEF, 1'b0, 8'h00);
    at_start(k + 3);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_neg(k + 3 + i);
      chk("stall_data", {24'b0, fifo_data}, 32'h0000_00BE);
      chk("stall_wr",   {31'b0, wr_inc},    32'd0);
    end
    at_start(k + 8);
    fifo_full = 1'b0;
    at_neg(k + 8);
    chk("stall_release_wr", {31'b0, wr_inc}, 32'd1);
    at_neg(k + 10 + CX);
    chk("stall_busy_lo", {31'b0, busy}, 32'd0);

    // Overflow: FULL held, four RD pulses into a 2-deep queue plus holding register
    k = cyc + 2;
    for (int i = 1; i <= 3; i++) begin
      expect_byte(8'(i), -1);
      if (CX != 0) expect_byte(8'(i), -1);
    end
    at_start(k);
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_start(k + i);
      rd_vld  = 1'b1;
      rd_data = 8'(i + 1);
      at_neg(k + i);
      chk("ovf_quiet", {31'b0, overflow}, 32'd0);
    end
    at_start(k + 4);
    rd_vld = 1'b0;
    at_neg(k + 4);
    chk("ovf_pulse", {31'b0, overflow}, 32'd1);
    at_neg(k + 5);
    chk("ovf_pulse_end", {31'b0, overflow}, 32'd0);
    at_start(k + 7);
    fifo_full = 1'b0;
    at_neg(k + 13 + 3 * CX);
    chk("ovf_busy_lo", {31'b0, busy}, 32'd0);

    // Reset after the low byte of an ALU response: the high byte must never appear
    k = cyc + 2;
    expect_byte(8'hFE, k + 2);
    pulse(k, 1'b1, 16'hCAFE, 1'b0, 8'h00);
    at_start(k + 2);
    rst = 1'b1;
    at_start(k + 3);
    rst = 1'b0;
    at_neg(k + 3);
    chk("rst_mid_wr",   {31'b0, wr_inc}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy},   32'd0);
    at_neg(k + 15);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
